if_fetch_queue: RTL and testbench

Instruction-fetch front end between the PC register and decode. Each cycle it issues the current PC to instruction memory and holds each issued PC in an in-order queue until its instruction returns. It hands {pc, instr} pairs to decode with a valid/ready handshake. It also drives the PC stage's `stall` input (hold PC when a fetch cannot issue) and discards wrong-path fetches on a redirect flush.

---
 rtl/if_fetch_queue.sv | 132 +++++++++++++
 tb/tb_if_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue between the PC register and decode: issues PCs to imem,
// tracks in-order responses, and drops wrong-path ones after a flush. Option: FETCH_BYPASS_EN.
module if_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        stall_o,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] fill_ptr_q, fill_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] drop_q, drop_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [AW-1:0] wr_idx, fill_idx, rd_idx;
  logic [PW-1:0] alloc, inflight;
  logic [PW:0]   occupancy;
  logic          req_fire, head_filled, drop_zero, bypass, dec_fire;

  assign wr_idx    = wr_ptr_q[AW-1:0];
  assign fill_idx  = fill_ptr_q[AW-1:0];
  assign rd_idx    = rd_ptr_q[AW-1:0];
  assign alloc     = wr_ptr_q - rd_ptr_q;
  assign inflight  = wr_ptr_q - fill_ptr_q;
  // Pending drops still occupy capacity: their responses have not yet arrived.
  assign occupancy = {1'b0, alloc} + {1'b0, drop_q};

  assign imem_req_valid = !rst && !flush && (occupancy < DEPTH_W);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign stall_o        = rst || (!flush && !req_fire);

  assign head_filled = filled_q[rd_idx];
  assign drop_zero   = (drop_q == '0);

`ifdef FETCH_BYPASS_EN
  // With no filled head and no pending drops, the arriving response is the head.
  assign bypass = !head_filled && drop_zero && imem_resp_valid;
`else
  assign bypass = 1'b0;
`endif

  assign dec_valid = !rst && !flush && (head_filled || bypass);
  assign dec_fire  = dec_valid && dec_ready;
  assign dec_pc    = dec_valid ? pc_mem_q[rd_idx] : 32'h0;
  assign dec_instr = dec_valid ? (head_filled ? instr_mem_q[rd_idx] : imem_resp_data) : 32'h0;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    drop_d      = drop_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    filled_d    = filled_q;
    if (flush) begin
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      rd_ptr_d   = '0;
      filled_d   = '0;
      drop_d     = inflight + drop_q - PW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        pc_mem_d[wr_idx] = pc;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (imem_resp_valid) begin
        if (!drop_zero) begin
          drop_d = drop_q - 1'b1;
        end else begin
          fill_ptr_d = fill_ptr_q + 1'b1;
          if (!(bypass && dec_ready)) begin
            instr_mem_d[fill_idx] = imem_resp_data;
            filled_d[fill_idx]    = 1'b1;
          end
        end
      end
      if (dec_fire) begin
        rd_ptr_d         = rd_ptr_q + 1'b1;
        filled_d[rd_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pc_mem_q[gi]    <= '0;
        instr_mem_q[gi] <= '0;
      end else begin
        pc_mem_q[gi]    <= pc_mem_d[gi];
        instr_mem_q[gi] <= instr_mem_d[gi];
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a PC-register model and an in-order imem model.
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, flush, imem_req_ready, imem_resp_valid, dec_ready, resp_en;
  logic [31:0] pc, npc, imem_resp_data;
  logic        stall_o, imem_req_valid, dec_valid;
  logic [31:0] imem_req_addr, dec_pc, dec_instr;

  int tests = 0;
  int fails = 0;
  int acc_cnt;
  logic [31:0] pend[$];
  logic [31:0] dq_pc[$];
  logic [31:0] dq_in[$];
  logic        s_req, s_stall, s_dv;
  logic [31:0] s_dpc, s_di, s_addr;

  if_fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .stall_o(stall_o),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; dec_ready = 1'b0; imem_req_ready = 1'b1; resp_en = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; pc = 32'h0; npc = 32'h0;
    pend.delete(); dq_pc.delete(); dq_in.delete(); acc_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock cycle: drive imem response, sample outputs, then advance bench models.
  task automatic tick();
    imem_resp_valid = resp_en && (pend.size() > 0);
    imem_resp_data  = imem_resp_valid ? instr_of(pend[0]) : 32'h0;
    #2;
    s_req = imem_req_valid; s_stall = stall_o; s_dv = dec_valid;
    s_dpc = dec_pc; s_di = dec_instr; s_addr = imem_req_addr;
    @(posedge clk); #1;
    if (s_req && imem_req_ready) begin pend.push_back(pc); acc_cnt++; end
    if (imem_resp_valid) void'(pend.pop_front());
    if (s_dv && dec_ready) begin dq_pc.push_back(s_dpc); dq_in.push_back(s_di); end
    if (flush) pc = npc;
    else if (!s_stall) pc = pc + 32'd4;
    $display("[TB] t=%0t req=%0b addr=%h stall=%0b dv=%0b dpc=%h dinstr=%h", $time, s_req, s_addr, s_stall, s_dv, s_dpc, s_di);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; dec_ready = 1'b1; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; pc = 32'h40;
    #3;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL reset_stall got %b want 1", stall_o); end
    tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL reset_dec_valid got %b want 0", dec_valid); end
    tests++; if (dec_pc !== 32'h0) begin fails++; $display("FAIL reset_dec_pc got %h want 0", dec_pc); end
  endtask

  task automatic test_stream();
    int first_dv, exp_first;
`ifdef FETCH_BYPASS_EN
    exp_first = 1;
`else
    exp_first = 2;
`endif
    do_reset();
    dec_ready = 1'b1; resp_en = 1'b1; first_dv = -1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (s_dv && first_dv < 0) first_dv = c;
      tests++; if (s_stall !== 1'b0) begin fails++; $display("FAIL stream_stall cycle %0d got %b want 0", c, s_stall); end
    end
    tests++; if (first_dv != exp_first) begin fails++; $display("FAIL stream_latency got %0d want %0d", first_dv, exp_first); end
    tests++; if (dq_pc.size() != 8 - exp_first) begin fails++; $display("FAIL stream_count got %0d want %0d", dq_pc.size(), 8 - exp_first); end
    if (dq_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (dq_pc[i] !== 32'(4 * i) || dq_in[i] !== instr_of(32'(4 * i))) begin
          fails++; $display("FAIL stream_order %0d got (%h,%h) want (%h,%h)", i, dq_pc[i], dq_in[i], 32'(4 * i), instr_of(32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dec_ready = 1'b0; resp_en = 1'b1;
    repeat (6) tick();
    tests++; if (acc_cnt != 4) begin fails++; $display("FAIL bp_accepts got %0d want 4", acc_cnt); end
    tests++; if (s_stall !== 1'b1) begin fails++; $display("FAIL bp_stall got %b want 1", s_stall); end
    tests++; if (pc !== 32'h10) begin fails++; $display("FAIL bp_pc_hold got %h want 00000010", pc); end
    tests++; if (s_dv !== 1'b1 || s_dpc !== 32'h0 || s_di !== instr_of(32'h0)) begin
      fails++; $display("FAIL bp_hold got dv=%b (%h,%h) want dv=1 (00000000,%h)", s_dv, s_dpc, s_di, instr_of(32'h0));
    end
    dec_ready = 1'b1;
    tick();
    tests++; if (s_stall !== 1'b1 || dq_pc.size() != 1) begin
      fails++; $display("FAIL bp_pop_cycle got stall=%b pops=%0d want stall=1 pops=1", s_stall, dq_pc.size());
    end
    tick();
    tests++; if (s_req !== 1'b1 || s_stall !== 1'b0 || s_addr !== 32'h10) begin
      fails++; $display("FAIL bp_reissue got req=%b stall=%b addr=%h want 1 0 00000010", s_req, s_stall, s_addr);
    end
  endtask

  task automatic test_imem_stall();
    do_reset();
    imem_req_ready = 1'b0; dec_ready = 1'b1; resp_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++; if (s_stall !== 1'b1) begin fails++; $display("FAIL imem_stall cycle %0d got %b want 1", c, s_stall); end
    end
    tests++; if (pc !== 32'h0 || acc_cnt != 0) begin fails++; $display("FAIL imem_hold got pc=%h acc=%0d want 0 0", pc, acc_cnt); end
    imem_req_ready = 1'b1;
    tick();
    tests++; if (s_stall !== 1'b0 || pc !== 32'h4) begin fails++; $display("FAIL imem_resume got stall=%b pc=%h want 0 00000004", s_stall, pc); end
    repeat (3) tick();
    tests++; if (dq_pc.size() == 0 || dq_pc[0] !== 32'h0) begin fails++; $display("FAIL imem_first_decode got n=%0d want pc 0 delivered", dq_pc.size()); end
  endtask

  task automatic test_flush();
    int stale;
    do_reset();
    dec_ready = 1'b0; resp_en = 1'b0;
    tick();
    resp_en = 1'b1; tick();
    resp_en = 1'b0; tick();
    tests++; if (s_dv !== 1'b1) begin fails++; $display("FAIL flush_prefill got dv=%b want 1", s_dv); end
    flush = 1'b1; npc = 32'h100; dec_ready = 1'b1;
    tick();
    tests++; if (s_dv !== 1'b0 || s_stall !== 1'b0 || s_req !== 1'b0) begin
      fails++; $display("FAIL flush_cycle got dv=%b stall=%b req=%b want 0 0 0", s_dv, s_stall, s_req);
    end
    tests++; if (pc !== 32'h100) begin fails++; $display("FAIL flush_npc got %h want 00000100", pc); end
    flush = 1'b0; resp_en = 1'b1;
    dq_pc.delete(); dq_in.delete();
    repeat (8) tick();
    stale = 0;
    foreach (dq_pc[i]) if (dq_pc[i] < 32'h100) stale++;
    tests++; if (stale != 0) begin fails++; $display("FAIL flush_stale got %0d stale want 0", stale); end
    tests++; if (dq_pc.size() < 2 || dq_pc[0] !== 32'h100 || dq_in[0] !== instr_of(32'h100) || dq_pc[1] !== 32'h104) begin
      fails++; $display("FAIL flush_refetch got n=%0d first=%h want first 00000100 then 00000104", dq_pc.size(), (dq_pc.size() > 0) ? dq_pc[0] : 32'hx);
    end
  endtask

  task automatic test_flush_resp();
    do_reset();
    dec_ready = 1'b0; resp_en = 1'b0;
    repeat (3) tick();
    flush = 1'b1; npc = 32'h200; resp_en = 1'b1;
    tick();
    tests++; if (s_req !== 1'b0 || s_dv !== 1'b0) begin fails++; $display("FAIL fr_flush_cycle got req=%b dv=%b want 0 0", s_req, s_dv); end
    flush = 1'b0; resp_en = 1'b0; acc_cnt = 0;
    repeat (4) tick();
    tests++; if (acc_cnt != 2) begin fails++; $display("FAIL fr_drop_capacity got %0d accepts want 2", acc_cnt); end
    tests++; if (s_stall !== 1'b1) begin fails++; $display("FAIL fr_full_stall got %b want 1", s_stall); end
    resp_en = 1'b1; dec_ready = 1'b1;
    dq_pc.delete(); dq_in.delete();
    repeat (8) tick();
    tests++; if (dq_pc.size() == 0 || dq_pc[0] !== 32'h200 || dq_in[0] !== instr_of(32'h200)) begin
      fails++; $display("FAIL fr_first_decode got n=%0d first=%h want 00000200", dq_pc.size(), (dq_pc.size() > 0) ? dq_pc[0] : 32'hx);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    resp_en = 1'b0; dec_ready = 1'b1;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    tests++; if (imem_req_valid !== 1'b0 || stall_o !== 1'b1 || dec_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_outputs got req=%b stall=%b dv=%b want 0 1 0", imem_req_valid, stall_o, dec_valid);
    end
    pc = 32'h0; pend.delete(); dq_pc.delete(); dq_in.delete();
    imem_resp_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    resp_en = 1'b1;
    tick();
    tests++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin fails++; $display("FAIL midrst_first_req got req=%b addr=%h want 1 00000000", s_req, s_addr); end
    repeat (3) tick();
    tests++; if (dq_pc.size() == 0 || dq_pc[0] !== 32'h0 || dq_in[0] !== instr_of(32'h0)) begin
      fails++; $display("FAIL midrst_decode got n=%0d want pc 0 with its instr", dq_pc.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_imem_stall();
    test_flush();
    test_flush_resp();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
